// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding, ALU opcode map and default width for alu_sequencer.
package alu_seq_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CAPT = 2'd2} state_t;
  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_DBLA  = 3'd1;
  localparam logic [2:0] OP_INCB  = 3'd2;
  localparam logic [2:0] OP_BSUBQ = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_OR    = 3'd5;
  localparam logic [2:0] OP_NOTB  = 3'd6;
  localparam logic [2:0] OP_ZERO  = 3'd7;
endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREGS x WIDTH register file, two async read ports,
// one write path where the ALU writeback beats a direct load to the same register.
module alu_seq_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  localparam int RA_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  i_ra_addr,
  input  logic [RA_W-1:0]  i_rb_addr,
  output logic [WIDTH-1:0] o_ra_data,
  output logic [WIDTH-1:0] o_rb_data,
  input  logic             i_wb_en,
  input  logic [RA_W-1:0]  i_wb_addr,
  input  logic [WIDTH-1:0] i_wb_data,
  input  logic             i_ld_en,
  input  logic [RA_W-1:0]  i_ld_addr,
  input  logic [WIDTH-1:0] i_ld_data
);
  logic [WIDTH-1:0] r_regs [NREGS];
  assign o_ra_data = r_regs[i_ra_addr];
  assign o_rb_data = r_regs[i_rb_addr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_regs <= '{default: '0};
    else
      for (int i = 0; i < NREGS; i++)
        if (i_wb_en && i_wb_addr == RA_W'(i)) r_regs[i] <= i_wb_data;
        else if (i_ld_en && i_ld_addr == RA_W'(i)) r_regs[i] <= i_ld_data;
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one instruction at a time to an external combinational ALU and writes back.
// ALU_SEQ_OUTREG_EN adds a CAPT state that registers the ALU outputs before writeback.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = 4,
  localparam int RA_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [RA_W-1:0]  instr_rd,
  input  logic [RA_W-1:0]  instr_ra,
  input  logic [RA_W-1:0]  instr_rb,
  input  logic             instr_cin,
  input  logic             ld_en,
  input  logic [RA_W-1:0]  ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_c,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_w,
  input  logic             alu_zer,
  input  logic             alu_neg,
  output logic [WIDTH-1:0] result,
  output logic             zer_flag,
  output logic             neg_flag,
  output logic             done
);
  state_t           r_state, w_next;
  logic [2:0]       r_op;
  logic [RA_W-1:0]  r_rd;
  logic             r_cin, r_zer, r_neg, r_done;
  logic [WIDTH-1:0] r_opa, r_opb, r_result;
  logic [WIDTH-1:0] w_ra_data, w_rb_data, w_wb_data;
  logic             w_accept, w_wb_en, w_wb_zer, w_wb_neg;
  assign w_accept = instr_valid && r_state == IDLE;
`ifdef ALU_SEQ_OUTREG_EN
  logic [WIDTH-1:0] r_cap_w;
  logic             r_cap_zer, r_cap_neg;
  assign w_wb_en   = r_state == CAPT;
  assign w_wb_data = r_cap_w;
  assign w_wb_zer  = r_cap_zer;
  assign w_wb_neg  = r_cap_neg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_w   <= '0;
      r_cap_zer <= 1'b0;
      r_cap_neg <= 1'b0;
    end else if (r_state == EXEC) begin
      r_cap_w   <= alu_w;
      r_cap_zer <= alu_zer;
      r_cap_neg <= alu_neg;
    end
  end
  always_comb
    w_next = r_state == IDLE ? (instr_valid ? EXEC : IDLE) : r_state == EXEC ? CAPT : IDLE;
`else
  assign w_wb_en   = r_state == EXEC;
  assign w_wb_data = alu_w;
  assign w_wb_zer  = alu_zer;
  assign w_wb_neg  = alu_neg;
  always_comb
    w_next = (r_state == IDLE && instr_valid) ? EXEC : IDLE;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Operand latches double as the ALU drive registers, so alu_* hold between instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_cin    <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_zer    <= 1'b0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_wb_en;
      if (w_accept) begin
        r_op  <= instr_op;
        r_rd  <= instr_rd;
        r_cin <= instr_cin;
        r_opa <= w_ra_data;
        r_opb <= w_rb_data;
      end
      if (w_wb_en) begin
        r_result <= w_wb_data;
        r_zer    <= w_wb_zer;
        r_neg    <= w_wb_neg;
      end
    end
  end
  alu_seq_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_ra_addr (instr_ra),
    .i_rb_addr (instr_rb),
    .o_ra_data (w_ra_data),
    .o_rb_data (w_rb_data),
    .i_wb_en   (w_wb_en),
    .i_wb_addr (r_rd),
    .i_wb_data (w_wb_data),
    .i_ld_en   (ld_en),
    .i_ld_addr (ld_addr),
    .i_ld_data (ld_data)
  );
  assign instr_ready = r_state == IDLE;
  assign alu_a       = r_opa;
  assign alu_b       = r_opb;
  assign alu_c       = r_cin;
  assign alu_opcode  = r_op;
  assign result      = r_result;
  assign zer_flag    = r_zer;
  assign neg_flag    = r_neg;
  assign done        = r_done;
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Sequences the team's 16-bit, 8-opcode combinational ALU.
- Holds a small register file and accepts one instruction at a time over a valid/ready handshake.
- Per instruction: reads ra/rb, drives ALU operands/opcode/carry-in, writes ALU result to rd, latches zero/negative flags, pulses done.
- Sits between the instruction source (bench or future control unit) and the external ALU instance.

Parameters:
WIDTH, 16, datapath width (ALU operand/result width)
NREGS, 4, register file depth; address width RA_W = clog2(NREGS)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
instr_valid  in  1  instruction present
instr_ready  out  1  sequencer can accept (high only in IDLE)
instr_op  in  3  ALU opcode 0..7
instr_rd  in  RA_W  destination register
instr_ra  in  RA_W  operand A register
instr_rb  in  RA_W  operand B register
instr_cin  in  1  carry-in (meaningful for opcode 0 only)
ld_en  in  1  direct register load strobe
ld_addr  in  RA_W  load address
ld_data  in  WIDTH  load data
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_c  out  1  to ALU C
alu_opcode  out  3  to ALU opcode
alu_w  in  WIDTH  ALU result
alu_zer  in  1  ALU zero flag
alu_neg  in  1  ALU negative flag
result  out  WIDTH  last written result
zer_flag  out  1  last zero flag
neg_flag  out  1  last negative flag
done  out  1  one-cycle pulse, result/flags valid

Behaviour:
- Reset (async, any state): state=IDLE; all registers, result, flags, done, operand latches = 0.
  - instr_ready=1 and alu_* = 0 after reset release.
- States: IDLE, EXEC (+ CAPT with the optional feature).
- IDLE:
  - instr_ready=1.
  - On the edge with instr_valid&instr_ready: latch op, rd, cin, regs[ra] into opa, regs[rb] into opb; go to EXEC.
  - instr_valid low: remain in IDLE.
- EXEC:
  - instr_ready=0; alu_a=opa, alu_b=opb, alu_opcode=op, alu_c=cin.
  - At the closing edge: regs[rd]<=alu_w, result<=alu_w, zer_flag<=alu_zer, neg_flag<=alu_neg, done<=1; go to IDLE.
- Outside EXEC: alu_* hold the last driven values (registered, no glitching).
- done:
  - High for exactly the cycle after writeback, coinciding with IDLE.
  - A new instruction may be accepted in that same cycle.
  - Sustained throughput: 1 instruction per 2 cycles.
- Latency: accept edge E0, write edge E1; result visible and done=1 in the cycle after E1.
- Operands are latched at accept: rd==ra/rb hazards are impossible. ra==rb is legal.
- Every opcode (including 7 -> 0) writes rd and updates both flags.
- ld_en:
  - Writes regs[ld_addr]<=ld_data in any state.
  - Same edge as an EXEC writeback to the same address: writeback wins.
  - Same edge as an accept reading ld_addr: the operand gets the old value (no bypass).
- Arithmetic is entirely in the ALU. The sequencer never modifies data; all widths are WIDTH, two's complement.
- Reset mid-EXEC: instruction aborted, no write, done stays 0.

Optional Feature:
- Macro: ALU_SEQ_OUTREG_EN.
- Defined:
  - EXEC is followed by CAPT. At the EXEC-closing edge, alu_w/alu_zer/alu_neg are registered internally.
  - CAPT closing edge performs the writeback.
  - Latency +1 cycle (write at E2); throughput 1 per 3 cycles.
  - The ld_en collision rule applies at the CAPT edge.
- Undefined: behaviour exactly as above.

Decomposition:
- Package alu_seq_pkg:
  - state enum (IDLE, EXEC, CAPT);
  - opcode constants OP_ADD=0, OP_DBLA=1, OP_INCB=2, OP_BSUBQ=3, OP_AND=4, OP_OR=5, OP_NOTB=6, OP_ZERO=7;
  - WIDTH default.
- One natural sub-module: alu_seq_regfile, with NREGS x WIDTH, two async read ports, and a write port carrying the priority mux (writeback over ld_en).

Test Plan:
- Load R0=5, R1=3; op0 rd=2 ra=0 rb=1 cin=1 -> done one cycle after writeback edge; R2=result=9, zer=0, neg=0.
- Load R0=0x8000; op1 rd=3 ra=0 rb=0 -> result=0x8000 (2*0x8000+0x8000 wraps), neg=1, zer=0.
- Load R1=16; op3 rd=1 ra=1 rb=1 -> R1=12; then op7 rd=1 -> result=0, zer=1, neg=0.
- instr_valid held high for 3 instructions -> instr_ready low during each EXEC; accepts spaced exactly 2 cycles apart (3 with ALU_SEQ_OUTREG_EN).
- ld_en to R2=7 on the same edge as an op6 writeback to R2 with B=0 -> R2=0xFFFF (writeback wins).
- Assert rst during EXEC -> immediate IDLE, all registers 0, no done pulse, instr_ready=1 after release.
